// File: rtl/faddsub_if.sv
// Operand/result handshake bundle for the pipelined single-precision adder/subtractor.
interface faddsub_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      x1;
  logic [31:0]      x2;
  logic             sub;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      y;
  logic [TAG_W-1:0] tag_out;
  logic             ovf;

  // Producer/consumer side (drives operands, takes results)
  modport master (
    output in_valid, x1, x2, sub, tag_in, out_ready,
    input  in_ready, out_valid, y, tag_out, ovf
  );

  // Arithmetic block side
  modport slave (
    input  in_valid, x1, x2, sub, tag_in, out_ready,
    output in_ready, out_valid, y, tag_out, ovf
  );
endinterface

// File: rtl/faddsub_pipe.sv
// Pipelined IEEE-754 single-precision add/subtract with sideband tag.
// Denormals flush to zero, round to nearest even, overflow saturates to
// infinity with ovf set. The pipeline advances under one global enable that
// drops whenever a valid result is not being taken by the consumer.
module faddsub_pipe #(
  parameter int LAT   = 3,
  parameter int TAG_W = 4
) (
  input  logic      clk,
  input  logic      rst,
  faddsub_if.slave  io
);

  logic                 stall;
  logic [LAT-1:0]       vld;
  logic [31:0]          y_q   [LAT];
  logic [TAG_W-1:0]     tag_q [LAT];
  logic [LAT-1:0]       ovf_q;

  // Datapath signals
  logic [31:0] b_eff;
  logic        swap;
  logic [31:0] big;
  logic [31:0] sml;
  logic        eff_sub;
  logic [7:0]  d;
  logic [4:0]  sh_amt;
  logic [55:0] wide;
  logic [26:0] al;
  logic [26:0] bm;
  logic [27:0] sum;
  logic [9:0]  exp_w;
  logic [4:0]  lz;
  logic [4:0]  sh;
  logic [26:0] norm;
  logic [9:0]  exp_n;
  logic        rnd;
  logic [23:0] mr;
  logic [9:0]  exp_r;
  logic [31:0] res_y;
  logic        res_ovf;

  assign stall        = vld[LAT-1] & ~io.out_ready;
  assign io.in_ready  = rst | ~stall;
  assign io.out_valid = vld[LAT-1];
  assign io.y         = y_q[LAT-1];
  assign io.tag_out   = tag_q[LAT-1];
  assign io.ovf       = ovf_q[LAT-1];

  // Full add/sub evaluated ahead of the first stage; later stages only delay it.
  always_comb begin
    b_eff   = {io.x2[31] ^ io.sub, io.x2[30:0]};
    // Magnitude order: exponent then mantissa equals an unsigned compare of bits [30:0]
    swap    = (b_eff[30:0] > io.x1[30:0]);
    big     = swap ? b_eff : io.x1;
    sml     = swap ? io.x1 : b_eff;
    eff_sub = big[31] ^ sml[31];
    d       = big[30:23] - sml[30:23];
    sh_amt  = (d > 8'd31) ? 5'd31 : d[4:0];
    // Shift with 32 spare bits below the mantissa so guard/round/sticky survive
    wide    = {1'b1, sml[22:0], 32'b0} >> sh_amt;
    al      = {wide[55:30], |wide[29:0]};
    bm      = {1'b1, big[22:0], 3'b000};
    sum     = eff_sub ? ({1'b0, bm} - {1'b0, al}) : ({1'b0, bm} + {1'b0, al});
    exp_w   = {2'b00, big[30:23]};

    lz = 5'd0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    sh    = 5'd0;
    norm  = '0;
    exp_n = exp_w;
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = exp_w + 10'd1;
    end else begin
      // Left shift capped so exponent stays >= 1; a still-unnormalized value underflows
      sh    = ({5'b0, lz} >= exp_w) ? 5'(exp_w - 10'd1) : lz;
      norm  = sum[26:0] << sh;
      exp_n = exp_w - {5'b0, sh};
    end

    rnd   = norm[2] & (norm[1] | norm[0] | norm[3]);
    mr    = {1'b0, norm[25:3]} + {23'b0, rnd};
    exp_r = mr[23] ? (exp_n + 10'd1) : exp_n;

    res_ovf = 1'b0;
    if (io.x1[30:23] == 8'd0) begin
      res_y = b_eff;
    end else if (b_eff[30:23] == 8'd0) begin
      res_y = io.x1;
    end else if (sum == 28'd0) begin
      res_y = '0;
    end else if (!sum[27] && !norm[26]) begin
      res_y = {big[31], 31'b0};
    end else if (exp_r >= 10'd255) begin
      res_y   = {big[31], 8'hFF, 23'h0};
      res_ovf = 1'b1;
    end else begin
      res_y = {big[31], exp_r[7:0], mr[22:0]};
    end
  end

  // Stage registers: cleared on reset, frozen as a whole while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= '0;
      ovf_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        y_q[i]   <= '0;
        tag_q[i] <= '0;
      end
    end else if (!stall) begin
      vld[0]   <= io.in_valid;
      y_q[0]   <= res_y;
      tag_q[0] <= io.tag_in;
      ovf_q[0] <= res_ovf;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld[i]   <= vld[i-1];
        y_q[i]   <= y_q[i-1];
        tag_q[i] <= tag_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
      end
    end
  end

endmodule
